// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions.
//   tx_states_t    : transmitter FSM encoding
//   MaxDataLength  : widest supported data word (parity helper input width)
//   cycles_per_bit : system clock cycles per line bit (integer division)
//   parity_bit     : even/odd parity of a data word (zero-extended to MaxDataLength)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_states_t;

    localparam int MaxDataLength = 9;

    function automatic int cycles_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

    // Zero-extension of narrower words does not change the XOR reduction.
    function automatic logic parity_bit(input logic [MaxDataLength-1:0] data, input logic even);
        logic result;
        if (even) begin
            result = ^data;
        end else begin
            result = ~^data;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts system clock cycles within one line bit.
//   i_clk      : system clock
//   i_rst      : asynchronous, active-high reset
//   i_clear    : synchronous clear of the cycle counter
//   o_bit_tick : high on the last cycle of each bit (counter == CyclesPerBit-1)
module uart_baud_counter #(
    parameter int CyclesPerBit = 434
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_bit_tick
);

    localparam int CntW = (CyclesPerBit > 1) ? $clog2(CyclesPerBit) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CyclesPerBit - 1);

    logic [CntW-1:0] r_cnt;

    assign o_bit_tick = (r_cnt == LastCnt);

    // Cycle counter: wraps to zero after the last cycle of a bit or on clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= {CntW{1'b0}};
        end else if (i_clear || o_bit_tick) begin
            r_cnt <= {CntW{1'b0}};
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter fed by a first-word-fall-through TX FIFO.
// Frame: start bit (0), DataLength data bits LSB first, optional parity, stop (1).
// Build option: define UART_TX_TWO_STOP_EN for a two-bit stop period.
//   i_clk             : system clock (single domain)
//   i_rst             : asynchronous, active-high reset (aborts any frame)
//   i_tx_data         : FIFO head word, valid while i_tx_fifo_empty=0
//   i_tx_fifo_empty   : FIFO empty flag
//   o_tx_fifo_read_en : one-cycle pop strobe; head word captured on that edge
//   o_tx              : registered serial line, idle high
//   o_tx_busy         : high from frame start until the end of the last stop bit
//   o_tx_done         : one-cycle pulse on the final cycle of each stop period
module uart_tx
    import uart_pkg::*;
#(
    parameter int   DataLength      = 8,
    parameter int   SystemClockFreq = 50_000_000,
    parameter int   BaudRate        = 115200,
    parameter logic Parity          = 1'b0,
    parameter logic ParityEven      = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DataLength-1:0] i_tx_data,
    input  logic                  i_tx_fifo_empty,
    output logic                  o_tx_fifo_read_en,
    output logic                  o_tx,
    output logic                  o_tx_busy,
    output logic                  o_tx_done
);

    localparam int CyclesPerBit = cycles_per_bit(SystemClockFreq, BaudRate);
    localparam int BitCntW      = $clog2(DataLength);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DataLength - 1);

    tx_states_t              r_state;
    tx_states_t              w_next_state;
    logic [DataLength-1:0]   r_shift;
    logic [DataLength-1:0]   w_shift_next;
    logic [BitCntW-1:0]      r_bit_cnt;
    logic [BitCntW-1:0]      w_bit_cnt_next;
    logic                    r_parity;
    logic                    r_tx;
    logic                    w_tx_next;
    logic                    w_bit_tick;
    logic                    w_stop_last;
    logic                    w_stop_tick;
    logic                    w_pop;
    logic                    w_clear;

    // Counter is held at zero while idle and restarted on every pop so the
    // start bit gets a full bit period.
    assign w_clear = w_pop || (r_state == IDLE);

    uart_baud_counter #(
        .CyclesPerBit (CyclesPerBit)
    ) u_baud_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_clear),
        .o_bit_tick (w_bit_tick)
    );

`ifdef UART_TX_TWO_STOP_EN
    logic r_stop_cnt;

    // Stop-bit counter: 0 during the first stop bit, 1 during the second.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stop_cnt <= 1'b0;
        end else if (w_pop) begin
            r_stop_cnt <= 1'b0;
        end else if ((r_state == STOP) && w_bit_tick) begin
            r_stop_cnt <= ~r_stop_cnt;
        end else begin
            r_stop_cnt <= r_stop_cnt;
        end
    end

    assign w_stop_last = r_stop_cnt;
`else
    assign w_stop_last = 1'b1;
`endif

    // Final cycle of the stop period: done, optional back-to-back pop, exit.
    assign w_stop_tick = (r_state == STOP) && w_bit_tick && w_stop_last;

    // Pop gated by reset so nothing is consumed while the block is held in reset.
    assign w_pop = !i_rst && !i_tx_fifo_empty && ((r_state == IDLE) || w_stop_tick);

    assign o_tx_fifo_read_en = w_pop;
    assign o_tx_done         = w_stop_tick;
    assign o_tx_busy         = (r_state != IDLE);
    assign o_tx              = r_tx;

    // Next-state, shift register, bit counter and next line value.
    always_comb begin
        w_next_state   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_tx_next      = r_tx;
        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
            end
            START: begin
                if (w_bit_tick) begin
                    w_next_state   = DATA;
                    w_bit_cnt_next = {BitCntW{1'b0}};
                    w_tx_next      = r_shift[0];
                end else begin
                    w_next_state = START;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    // Bit 0 of the post-shift word is the next line value.
                    w_shift_next = {1'b0, r_shift[DataLength-1:1]};
                    if (r_bit_cnt == LastBit) begin
                        w_next_state = Parity ? PARITY : STOP;
                        w_tx_next    = Parity ? r_parity : 1'b1;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BitCntW'(1);
                        w_tx_next      = r_shift[1];
                    end
                end else begin
                    w_next_state = DATA;
                end
            end
            PARITY: begin
                if (w_bit_tick) begin
                    w_next_state = STOP;
                    w_tx_next    = 1'b1;
                end else begin
                    w_next_state = PARITY;
                end
            end
            STOP: begin
                if (w_stop_tick) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = STOP;
                end
                w_tx_next = 1'b1;
            end
            default: begin
                w_next_state = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
        // A pop overrides: capture the head word and start the frame on this edge.
        if (w_pop) begin
            w_next_state   = START;
            w_shift_next   = i_tx_data;
            w_bit_cnt_next = {BitCntW{1'b0}};
            w_tx_next      = 1'b0;
        end else begin
            w_next_state = w_next_state;
        end
    end

    // Frame state registers; reset returns the line high immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_shift   <= {DataLength{1'b0}};
            r_bit_cnt <= {BitCntW{1'b0}};
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
            if (w_pop) begin
                r_parity <= parity_bit(MaxDataLength'(i_tx_data), ParityEven);
            end else begin
                r_parity <= r_parity;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at CyclesPerBit = 10.
// Three instances: no parity, even parity, odd parity.
module tb_uart_tx;
    import uart_pkg::*;

`ifdef UART_TX_TWO_STOP_EN
    localparam int StopBits = 2;
`else
    localparam int StopBits = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d_m, d_p;
    logic       e_m, e_p;
    logic       tx_m, rd_m, busy_m, done_m;
    logic       tx_pe, rd_pe, busy_pe, done_pe;
    logic       tx_po, rd_po, busy_po, done_po;
    int         sel;
    logic       m_tx, m_rd, m_busy, m_done;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    uart_tx #(.DataLength(8), .SystemClockFreq(1_000_000), .BaudRate(100_000),
              .Parity(1'b0), .ParityEven(1'b0)) u_dut_m (
        .i_clk(clk), .i_rst(rst), .i_tx_data(d_m), .i_tx_fifo_empty(e_m),
        .o_tx_fifo_read_en(rd_m), .o_tx(tx_m), .o_tx_busy(busy_m), .o_tx_done(done_m));

    uart_tx #(.DataLength(8), .SystemClockFreq(1_000_000), .BaudRate(100_000),
              .Parity(1'b1), .ParityEven(1'b1)) u_dut_pe (
        .i_clk(clk), .i_rst(rst), .i_tx_data(d_p), .i_tx_fifo_empty(e_p),
        .o_tx_fifo_read_en(rd_pe), .o_tx(tx_pe), .o_tx_busy(busy_pe), .o_tx_done(done_pe));

    uart_tx #(.DataLength(8), .SystemClockFreq(1_000_000), .BaudRate(100_000),
              .Parity(1'b1), .ParityEven(1'b0)) u_dut_po (
        .i_clk(clk), .i_rst(rst), .i_tx_data(d_p), .i_tx_fifo_empty(e_p),
        .o_tx_fifo_read_en(rd_po), .o_tx(tx_po), .o_tx_busy(busy_po), .o_tx_done(done_po));

    // Selects which instance the frame checker observes.
    always_comb begin
        case (sel)
            1: begin m_tx = tx_pe; m_rd = rd_pe; m_busy = busy_pe; m_done = done_pe; end
            2: begin m_tx = tx_po; m_rd = rd_po; m_busy = busy_po; m_done = done_po; end
            default: begin m_tx = tx_m; m_rd = rd_m; m_busy = busy_m; m_done = done_m; end
        endcase
    end

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called #1 after the pop edge; k counts samples taken #1 after each edge.
    task automatic frame_body(input logic [7:0] d, input bit has_par, input logic par,
                              input bit next_pop, input string tag);
        int   flen;
        int   last;
        int   b;
        int   line_err = 0;
        int   done_at  = -1;
        int   done_n   = 0;
        int   busy_n   = 0;
        int   pops     = 0;
        logic exp;
        flen = (1 + 8 + int'(has_par) + StopBits) * 10;
        last = next_pop ? flen - 1 : flen + 4;
        for (int k = 0; k <= last; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            b = k / 10;
            if (b == 0) exp = 1'b0;
            else if (b <= 8) exp = d[b-1];
            else if (has_par && b == 9) exp = par;
            else exp = 1'b1;
            if (m_tx !== exp) line_err++;
            if (m_done === 1'b1) begin done_n++; done_at = k; end
            if (m_busy === 1'b1) busy_n++;
            if (m_rd === 1'b1) pops++;
        end
        check_int({tag, " line errs"}, line_err, 0);
        check_int({tag, " done cycle"}, done_at, flen - 1);
        check_int({tag, " done count"}, done_n, 1);
        check_int({tag, " busy cycles"}, busy_n, flen);
        check_int({tag, " pops"}, pops, next_pop ? 1 : 0);
    endtask

    // Called #1 after an edge with the FIFO already made non-empty by the caller.
    task automatic pop_edge(input string tag);
        #1;
        check_int({tag, " read_en"}, int'(m_rd), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        rst = 1'b1; e_m = 1'b1; e_p = 1'b1; d_m = 8'h00; d_p = 8'h00; sel = 0;
        #3;
        check_int("reset tx", int'(tx_m), 1);
        check_int("reset busy", int'(busy_m), 0);
        check_int("reset done", int'(done_m), 0);
        check_int("reset read_en", int'(rd_m), 0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Single byte, no parity
        sel = 0; d_m = 8'hA5; e_m = 1'b0;
        pop_edge("a5");
        e_m = 1'b1;
        frame_body(8'hA5, 1'b0, 1'b0, 1'b0, "a5");

        // Even parity: 07 has three ones -> parity 1
        sel = 1; d_p = 8'h07; e_p = 1'b0;
        pop_edge("par even");
        e_p = 1'b1;
        frame_body(8'h07, 1'b1, 1'b1, 1'b0, "par even");

        // Odd parity on the same byte -> parity 0
        sel = 2; d_p = 8'h07; e_p = 1'b0;
        pop_edge("par odd");
        e_p = 1'b1;
        frame_body(8'h07, 1'b1, 1'b0, 1'b0, "par odd");

        // Back-to-back 55 then FF: second pop on the first done cycle
        sel = 0; d_m = 8'h55; e_m = 1'b0;
        pop_edge("b2b first");
        d_m = 8'hFF;
        frame_body(8'h55, 1'b0, 1'b0, 1'b1, "b2b first");
        check_int("b2b done with pop", int'(m_done & m_rd), 1);
        @(posedge clk); #1;
        e_m = 1'b1;
        frame_body(8'hFF, 1'b0, 1'b0, 1'b0, "b2b second");

        // Empty FIFO for 500 cycles: everything stays idle
        viol = 0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            if (tx_m !== 1'b1 || rd_m !== 1'b0 || busy_m !== 1'b0) viol++;
            if (tx_pe !== 1'b1 || rd_pe !== 1'b0 || busy_pe !== 1'b0) viol++;
            if (tx_po !== 1'b1 || rd_po !== 1'b0 || busy_po !== 1'b0) viol++;
        end
        check_int("idle violations", viol, 0);

        // Reset during data bit 3 of 00
        sel = 0; d_m = 8'h00; e_m = 1'b0;
        pop_edge("rst frame");
        e_m = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        check_int("pre-reset tx", int'(tx_m), 0);
        #2 rst = 1'b1;
        #1;
        check_int("async reset tx", int'(tx_m), 1);
        check_int("async reset busy", int'(busy_m), 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_int("post-reset state", int'(u_dut_m.r_state), int'(IDLE));
        check_int("post-reset tx", int'(tx_m), 1);
        check_int("post-reset read_en", int'(rd_m), 0);
        d_m = 8'h81; e_m = 1'b0;
        pop_edge("81 after rst");
        e_m = 1'b1;
        frame_body(8'h81, 1'b0, 1'b0, 1'b0, "81 after rst");

        // 3C: stop period length depends on the two-stop build option
        d_m = 8'h3C; e_m = 1'b0;
        pop_edge("3c");
        e_m = 1'b1;
        frame_body(8'h3C, 1'b0, 1'b0, 1'b0, "3c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
